addition_aligner: RTL

- Pre-addition operand alignment stage for the single-precision FP adder datapath; the inverse of the post-addition normalizer.
- Normalizer: left-shifts the sum and decrements the exponent. This block: right-shifts the smaller-exponent mantissa until both exponents match, keeping guard/round/sticky bits for later rounding.
- Iterative and multi-cycle (STEP bits per cycle), with valid/ready handshakes on both sides.
- Sits between operand unpack and the mantissa adder.

---
 rtl/addition_aligner_if.sv | 29 ++
 rtl/addition_aligner.sv | 96 +++++++++
 2 files changed

// File: rtl/addition_aligner_if.sv
// Operand-in / aligned-result-out handshake bundle for the FP adder alignment stage.
// The master side drives operands and out_ready; the slave side is the aligner.
interface addition_aligner_if #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 24
);
  logic              in_valid;
  logic              in_ready;
  logic [EXP_W-1:0]  in_ea;
  logic [MANT_W-1:0] in_ma;
  logic [EXP_W-1:0]  in_eb;
  logic [MANT_W-1:0] in_mb;
  logic              out_valid;
  logic              out_ready;
  logic [EXP_W-1:0]  out_e;
  logic [MANT_W-1:0] out_m_big;
  logic [MANT_W+2:0] out_m_small;
  logic              out_swap;

  modport master (
    output in_valid, in_ea, in_ma, in_eb, in_mb, out_ready,
    input  in_ready, out_valid, out_e, out_m_big, out_m_small, out_swap
  );

  modport slave (
    input  in_valid, in_ea, in_ma, in_eb, in_mb, out_ready,
    output in_ready, out_valid, out_e, out_m_big, out_m_small, out_swap
  );
endinterface

// File: rtl/addition_aligner.sv
// Pre-addition alignment: right-shifts the smaller-exponent mantissa up to STEP bits
// per cycle until exponents match, folding shifted-out bits into a sticky LSB.
module addition_aligner #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 24,
  parameter int STEP   = 1
) (
  input logic               clk,
  input logic               rst_n,
  addition_aligner_if.slave bus
);
  localparam int SM_W = MANT_W + 3;
  localparam logic [EXP_W-1:0] STEP_E = EXP_W'(STEP);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t            state, state_nxt;
  logic              in_ready, accept;
  logic [EXP_W-1:0]  remaining;
  logic [EXP_W-1:0]  e_q;
  logic [MANT_W-1:0] m_big_q;
  logic [SM_W-1:0]   small_q;
  logic              swap_q;

  logic              swap_in, flush;
  logic [EXP_W-1:0]  diff;
  logic [MANT_W-1:0] m_small_in;
  logic [EXP_W-1:0]  shamt, rem_nxt;
  logic [SM_W-1:0]   lost, shifted;

  assign accept = bus.in_valid && in_ready;

  // Operand compare; equal exponents keep A as the big operand.
  always_comb begin
    swap_in    = bus.in_eb > bus.in_ea;
    diff       = swap_in ? (bus.in_eb - bus.in_ea) : (bus.in_ea - bus.in_eb);
    flush      = 32'(diff) >= SM_W;
    m_small_in = swap_in ? bus.in_ma : bus.in_mb;
  end

  // One shift step; bits falling off the bottom are ORed into the sticky LSB.
  always_comb begin
    shamt      = (remaining > STEP_E) ? STEP_E : remaining;
    lost       = small_q & ~({SM_W{1'b1}} << shamt);
    shifted    = small_q >> shamt;
    shifted[0] = shifted[0] | (|lost);
    rem_nxt    = remaining - shamt;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: default assignment first so no path through this block leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = (diff == '0 || flush) ? DONE : SHIFT;
      SHIFT:   if (rem_nxt == '0) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready      = (state == IDLE);
    bus.in_ready  = in_ready;
    bus.out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q       <= '0;
      m_big_q   <= '0;
      small_q   <= '0;
      swap_q    <= 1'b0;
      remaining <= '0;
    end else if (state == IDLE && accept) begin
      swap_q    <= swap_in;
      e_q       <= swap_in ? bus.in_eb : bus.in_ea;
      m_big_q   <= swap_in ? bus.in_mb : bus.in_ma;
      small_q   <= flush ? {{(SM_W-1){1'b0}}, |m_small_in} : {m_small_in, 3'b000};
      remaining <= flush ? '0 : diff;
    end else if (state == SHIFT) begin
      small_q   <= shifted;
      remaining <= rem_nxt;
    end
  end

  assign bus.out_e       = e_q;
  assign bus.out_m_big   = m_big_q;
  assign bus.out_m_small = small_q;
  assign bus.out_swap    = swap_q;
endmodule
